// File: rtl/cactus_draw.sv
// cactus_draw: redraws two scrolling cacti through a valid/ready pixel-write port
package cactus_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WIN, OVER} state_t;
endpackage

module cactus_draw
    import cactus_pkg::*;
#(
    parameter int GROUND_Y = 200,
    parameter int CACTUS_W = 8,
    parameter int H_MAX    = 50,
    parameter int SCREEN_W = 320
) (
    input  logic       clk,
    input  logic       nRst,
    input  state_t     state,
    input  logic [8:0] pixel,
    input  logic [8:0] x_dist,
    input  logic [8:0] height1,
    input  logic [8:0] height2,
    input  logic       cactusMovement,
    input  logic       wr_ready,
    output logic       wr_valid,
    output logic [8:0] wr_x,
    output logic [7:0] wr_y,
    output logic       wr_color,
    output logic       drawDoneCactus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_ERASE1 = 3'd2;
    localparam logic [2:0] S_DRAW1  = 3'd3;
    localparam logic [2:0] S_ERASE2 = 3'd4;
    localparam logic [2:0] S_DRAW2  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [8:0] W1  = 9'(CACTUS_W - 1);
    localparam logic [7:0] HM  = 8'(H_MAX);
    localparam logic [7:0] GY1 = 8'(GROUND_Y - 1);
    localparam logic [9:0] SW  = 10'(SCREEN_W);

    logic [2:0] fsm;
    logic [8:0] snap_pixel, snap_xdist, snap_h1, snap_h2, prev_pixel, prev_xdist;
    logic [8:0] col, base, x, h_sel;
    logic [7:0] row, h_clamp, n_rows;
    logic       full, first_draw, erase, c2, active, skip, empty, last_row, last_col, fire;

    // Address of the current phase's column/row and the write port it drives
    always_comb begin
        erase          = fsm == S_ERASE1 || fsm == S_ERASE2;
        c2             = fsm == S_ERASE2 || fsm == S_DRAW2;
        active         = erase || fsm == S_DRAW1 || fsm == S_DRAW2;
        h_sel          = c2 ? snap_h2 : snap_h1;
        h_clamp        = h_sel > {1'b0, HM} ? HM : h_sel[7:0];
        n_rows         = erase ? HM : h_clamp;
        base           = erase ? (c2 ? prev_pixel - prev_xdist : prev_pixel)
                               : (c2 ? snap_pixel - snap_xdist : snap_pixel) + (full ? 9'd0 : W1);
        x              = base + col;
        empty          = n_rows == 8'd0;
        skip           = active && !empty && {1'b0, x} >= SW;
        wr_valid       = active && !empty && !skip;
        fire           = wr_valid && wr_ready;
        last_row       = row == n_rows - 8'd1;
        last_col       = !full || col == W1;
        wr_x           = wr_valid ? x : 9'd0;
        wr_y           = wr_valid ? GY1 - row : 8'd0;
        wr_color       = wr_valid && !erase;
        drawDoneCactus = fsm == S_DONE && state == RUN;
    end

    // Sequencer: trigger, snapshot, erase/draw both cacti, then commit positions
    always_ff @(posedge clk) begin
        if (!nRst) begin
            fsm        <= S_IDLE;
            row        <= '0;
            col        <= '0;
            full       <= 1'b0;
            first_draw <= 1'b1;
            prev_pixel <= '0;
            prev_xdist <= '0;
            snap_pixel <= '0;
            snap_xdist <= '0;
            snap_h1    <= '0;
            snap_h2    <= '0;
        end else if (fsm != S_IDLE && state != RUN) begin
            fsm        <= S_IDLE;
            row        <= '0;
            col        <= '0;
            first_draw <= 1'b1;
        end else begin
            case (fsm)
                S_IDLE: if (state == RUN && cactusMovement) fsm <= S_LATCH;
                S_LATCH: begin
                    snap_pixel <= pixel;
                    snap_xdist <= x_dist;
                    snap_h1    <= height1;
                    snap_h2    <= height2;
                    full       <= first_draw || pixel != prev_pixel + 9'd1;
                    row        <= '0;
                    col        <= '0;
                    fsm        <= S_ERASE1;
                end
                S_ERASE1, S_DRAW1, S_ERASE2, S_DRAW2: begin
                    if (empty) fsm <= fsm + 3'd1;
                    else if (skip || fire) begin
                        if (fire && !last_row) row <= row + 8'd1;
                        else begin
                            row <= '0;
                            col <= last_col ? 9'd0 : col + 9'd1;
                            if (last_col) fsm <= fsm + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    prev_pixel <= snap_pixel;
                    prev_xdist <= snap_xdist;
                    first_draw <= 1'b0;
                    fsm        <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cactus_draw.sv
// tb_cactus_draw: vector table, random redraws and corner sequences against a write-list model
module tb_cactus_draw;
    import cactus_pkg::*;

    localparam int GY = 200;
    localparam int CW = 8;
    localparam int HM = 50;
    localparam int SW = 320;

    typedef struct {int pixel; int xd; int h1; int h2; int mode; int exp_n; int lat;} vec_t;
    typedef struct {int x; int y; int c;} wr_t;

    logic       clk = 1'b0, nRst = 1'b0, cactusMovement = 1'b0, wr_ready = 1'b1;
    state_t     state_in = IDLE;
    logic [8:0] pixel = '0, x_dist = '0, height1 = '0, height2 = '0;
    logic       wr_valid, wr_color, drawDoneCactus;
    logic [8:0] wr_x;
    logic [7:0] wr_y;

    int n_chk = 0, n_fail = 0, ncyc = 0, first_v = -1, done_cnt = 0, done_cyc = 0, mode = 0;
    bit chk_stable = 1'b0, pstall = 1'b0;
    logic [18:0] phold = '0;
    wr_t got[$];
    wr_t exp_q[$];
    int m_prev = 0, m_xd = 0;
    bit m_first = 1'b1;

    cactus_draw dut (
        .clk(clk), .nRst(nRst), .state(state_in), .pixel(pixel), .x_dist(x_dist),
        .height1(height1), .height2(height2), .cactusMovement(cactusMovement),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .drawDoneCactus(drawDoneCactus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor on the falling edge: collects completed writes, stall stability, done pulses
    always @(negedge clk) begin
        wr_t w;
        ncyc++;
        if (chk_stable && pstall)
            check("stall_hold", int'({wr_valid, wr_x, wr_y, wr_color}), int'(phold));
        pstall = wr_valid && !wr_ready;
        phold  = {1'b1, wr_x, wr_y, wr_color};
        if (wr_valid && first_v < 0) first_v = ncyc;
        if (wr_valid && wr_ready) begin
            w.x = int'(wr_x);
            w.y = int'(wr_y);
            w.c = int'(wr_color);
            got.push_back(w);
        end
        if (drawDoneCactus) begin
            done_cnt++;
            done_cyc = ncyc;
        end
    end

    // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random
    initial forever begin
        @(posedge clk);
        #1 wr_ready = mode == 0 ? 1'b1 : mode == 1 ? ~wr_ready : 1'($urandom_range(0, 1));
    end

    // Expected write list of one redraw, from the column/row rules with plain arithmetic
    function automatic void model(input int p, input int xd, input int h1, input int h2);
        bit full;
        int ol, nl, h, ncol, xx;
        wr_t w;
        full = m_first || p != (m_prev + 1) % 512;
        ncol = full ? CW : 1;
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            ol = c == 1 ? (m_prev - m_xd + 512) % 512 : m_prev;
            nl = c == 1 ? (p - xd + 512) % 512 : p;
            h  = c == 1 ? h2 : h1;
            if (h > HM) h = HM;
            for (int k = 0; k < ncol; k++) begin
                xx = (ol + k) % 512;
                if (xx < SW)
                    for (int r = 0; r < HM; r++) begin
                        w.x = xx; w.y = GY - 1 - r; w.c = 0;
                        exp_q.push_back(w);
                    end
            end
            for (int k = 0; k < ncol; k++) begin
                xx = (nl + (full ? k : CW - 1)) % 512;
                if (xx < SW)
                    for (int r = 0; r < h; r++) begin
                        w.x = xx; w.y = GY - 1 - r; w.c = 1;
                        exp_q.push_back(w);
                    end
            end
        end
    endfunction

    task automatic compare_writes(input string tag);
        int bad;
        bad = -1;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (bad < 0 && (got[i].x != exp_q[i].x || got[i].y != exp_q[i].y || got[i].c != exp_q[i].c))
                bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s_seq: write %0d got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                     tag, bad, got[bad].x, got[bad].y, got[bad].c, exp_q[bad].x, exp_q[bad].y, exp_q[bad].c);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int t0;
        @(posedge clk);
        #1;
        model(v.pixel, v.xd, v.h1, v.h2);
        got.delete();
        done_cnt = 0; first_v = -1; mode = v.mode; chk_stable = 1'b1;
        pixel = 9'(v.pixel); x_dist = 9'(v.xd); height1 = 9'(v.h1); height2 = 9'(v.h2);
        state_in = RUN; cactusMovement = 1'b1; t0 = ncyc;
        @(posedge clk);
        #1 cactusMovement = 1'b0;
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk_stable = 1'b0;
        check({tag, "_done"}, done_cnt, 1);
        compare_writes(tag);
        if (v.exp_n >= 0) check({tag, "_n"}, got.size(), v.exp_n);
        if (v.lat > 0) check({tag, "_lat"}, first_v - t0, v.lat);
        m_prev = v.pixel; m_xd = v.xd; m_first = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int k;
        tbl = '{
            '{10,  100, 15, 40, 0, 920, 3},
            '{99,  130, 20, 15, 0, 560, 3},
            '{100, 130, 20, 15, 0, 70,  3},
            '{99,  130, 20, 15, 0, 560, 3},
            '{100, 130, 20, 15, 1, 70,  3},
            '{321, 189, 30, 60, 0, 800, 3},
            '{323, 189, 30, 60, 0, 800, 19},
            '{324, 189, 0,  0,  0, 50,  5},
            '{510, 5,   10, 5,  2, 465, 13}
        };
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(wr_valid), 0);
        check("rst_x", int'(wr_x), 0);
        check("rst_y", int'(wr_y), 0);
        check("rst_color", int'(wr_color), 0);
        check("rst_done", int'(drawDoneCactus), 0);
        @(posedge clk);
        #1 nRst = 1'b1;
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 12; i++) begin
            v.pixel = $urandom_range(0, 1) == 1 ? (m_prev + 1) % 512 : int'($urandom_range(0, 511));
            v.xd    = int'($urandom_range(0, 511));
            v.h1    = int'($urandom_range(0, 63));
            v.h2    = int'($urandom_range(0, 63));
            v.mode  = int'($urandom_range(0, 2));
            v.exp_n = -1;
            v.lat   = 0;
            run(v, $sformatf("rnd%0d", i));
        end
        // abort during the first draw phase, then the next redraw must be full
        run('{40, 30, 10, 10, 0, -1, 3}, "pre_abort");
        @(posedge clk);
        #1 done_cnt = 0; mode = 0; pixel = 9'd41; x_dist = 9'd30; height1 = 9'd10; height2 = 9'd10;
        state_in = RUN; cactusMovement = 1'b1;
        @(posedge clk);
        #1 cactusMovement = 1'b0;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (wr_valid && wr_color) break;
        end
        check("abort_reach_draw", int'(k < 500), 1);
        @(posedge clk);
        #1 state_in = OVER;
        @(negedge clk);
        @(negedge clk);
        check("abort_valid", int'(wr_valid), 0);
        repeat (5) @(posedge clk);
        check("abort_done", done_cnt, 0);
        m_first = 1'b1;
        run('{41, 30, 10, 10, 0, -1, 3}, "post_abort");
        // cactusMovement held through completion retriggers at once
        @(posedge clk);
        #1 done_cnt = 0; mode = 0; pixel = 9'd60; x_dist = 9'd30; height1 = 9'd5; height2 = 9'd5;
        state_in = RUN; cactusMovement = 1'b1;
        for (k = 0; k < 5000 && done_cnt == 0; k++) @(posedge clk);
        first_v = -1;
        for (k = 0; k < 50 && first_v < 0; k++) @(posedge clk);
        check("b2b_retrigger", first_v - done_cyc, 3);
        #1 cactusMovement = 1'b0;
        for (k = 0; k < 5000 && done_cnt < 2; k++) @(posedge clk);
        check("b2b_done2", done_cnt, 2);
        m_prev = 60; m_xd = 30; m_first = 1'b0;
        // reset in the middle of a redraw
        @(posedge clk);
        #1 done_cnt = 0; pixel = 9'd100; x_dist = 9'd50; height1 = 9'd20; height2 = 9'd20;
        state_in = RUN; cactusMovement = 1'b1;
        @(posedge clk);
        #1 cactusMovement = 1'b0;
        repeat (20) @(posedge clk);
        #1 nRst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_valid", int'(wr_valid), 0);
        check("rst_mid_x", int'(wr_x), 0);
        check("rst_mid_y", int'(wr_y), 0);
        got.delete();
        @(posedge clk);
        #1 nRst = 1'b1;
        repeat (6) @(posedge clk);
        check("rst_mid_writes", got.size(), 0);
        check("rst_mid_done", done_cnt, 0);
        m_prev = 0; m_xd = 0; m_first = 1'b1;
        run('{10, 100, 15, 40, 0, 920, 3}, "post_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cactus_draw.md
CACTUS_DRAW -- requirements
Module: cactus_draw

Interface
REQ-001 SHALL have parameter GROUND_Y, default 200: first row below the cacti; cactus bottom row is GROUND_Y-1.
REQ-002 SHALL have parameter CACTUS_W, default 8: cactus width in columns.
REQ-003 SHALL have parameter H_MAX, default 50: rows cleared per erased column.
REQ-004 SHALL have parameter SCREEN_W, default 320: columns x >= SCREEN_W are off-screen.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 nRst  input  1  synchronous, active-low reset.
REQ-007 state  input  state_t  game state (IDLE, RUN, WIN, OVER) from the shared package.
REQ-008 pixel  input  9  left-edge x of cactus 1; cactus 2 left edge = pixel - x_dist, mod 512.
REQ-009 x_dist  input  9  spacing between the two cacti.
REQ-010 height1, height2  input  9 each  cactus heights in rows.
REQ-011 cactusMovement  input  1  level request: position changed, redraw needed.
REQ-012 wr_ready  input  1  display accepts the current write.
REQ-013 wr_valid  output  1  write request valid.
REQ-014 wr_x  output  9  write column.
REQ-015 wr_y  output  8  write row.
REQ-016 wr_color  output  1  1 = cactus, 0 = background.
REQ-017 drawDoneCactus  output  1  one-cycle pulse when a redraw completes.

Function
REQ-018 SHALL implement FSM states S_IDLE, S_LATCH, S_ERASE1, S_DRAW1, S_ERASE2, S_DRAW2, S_DONE.
REQ-019 In S_IDLE, with state==RUN and cactusMovement==1, SHALL enter S_LATCH next cycle.
REQ-020 S_LATCH SHALL capture pixel, x_dist, height1 and height2 into snapshot registers; the inputs are ignored until the next S_LATCH.
REQ-021 S_LATCH SHALL set the full flag when the first_draw flag is set or pixel != prev_pixel+1 (mod 512); otherwise full is cleared.
REQ-022 Incremental mode, erase: SHALL erase column prev_left.
REQ-023 Incremental mode, draw: SHALL draw column new_left+CACTUS_W-1.
REQ-024 Full mode: SHALL erase columns prev_left..prev_left+CACTUS_W-1 and draw columns new_left..new_left+CACTUS_W-1.
REQ-025 Erase phase SHALL write color 0 to rows GROUND_Y-1 down to GROUND_Y-H_MAX, one column at a time, in ascending x.
REQ-026 Draw phase SHALL write color 1 to rows GROUND_Y-1 down to GROUND_Y-h, where h is the latched height; h==0 skips the phase.
REQ-027 h > H_MAX SHALL be clamped to H_MAX.
REQ-028 Column x arithmetic SHALL be 9-bit modulo 512.
REQ-029 A column with x >= SCREEN_W SHALL be skipped in one cycle with no write issued.
REQ-030 Order SHALL be S_ERASE1 -> S_DRAW1 -> S_ERASE2 -> S_DRAW2 -> S_DONE; cactus 1 uses pixel, cactus 2 uses pixel - x_dist.
REQ-031 Handshake: wr_x, wr_y and wr_color SHALL hold stable while wr_valid=1 and wr_ready=0; the write completes on wr_valid&&wr_ready.
REQ-032 Row and column counters SHALL advance only on a completed write or a skip.
REQ-033 Throughput SHALL be one write per cycle with wr_ready held 1.
REQ-034 First wr_valid SHALL assert the cycle after S_LATCH, i.e. 2 cycles after the trigger is sampled.
REQ-035 S_DONE SHALL pulse drawDoneCactus for exactly 1 cycle, load prev_pixel/prev_xdist from the snapshot, clear first_draw, and return to S_IDLE.
REQ-036 If cactusMovement is still 1 in S_IDLE after S_DONE, SHALL retrigger immediately; no request is lost.
REQ-037 state != RUN in any non-idle state SHALL abort to S_IDLE next cycle: wr_valid=0, no done pulse, first_draw set.

Reset
REQ-038 On clk edge with nRst=0: FSM=S_IDLE, wr_valid=0, wr_x=0, wr_y=0, wr_color=0, drawDoneCactus=0, prev_pixel=0, prev_xdist=0, first_draw=1, all counters 0.
REQ-039 Reset asserted mid-redraw SHALL take precedence over all else; no partial write completes after it.

Verification
REQ-040 Incremental: prev=99, pixel=100, x_dist=130, h1=20, h2=15, wr_ready=1 -> 50 erases at x=99 (y 199..150), 20 draws at x=107 (y 199..180), cactus 2 (x 481/489) skipped, done pulse; 70 writes total.
REQ-041 Backpressure: wr_ready toggles 1/0 every cycle on REQ-040 -> identical write sequence, outputs stable during stalls, 70 writes.
REQ-042 First draw after reset, pixel=10, x_dist=100, h1=15, h2=40 -> full mode: 8x50 erases at x=0..7, 8x15 draws at x=10..17, cactus 2 at x 422.. fully skipped.
REQ-043 Wrap: prev=321, pixel=323 (-189) -> full mode; all columns >= 320 skipped, no writes with wr_x >= 320.
REQ-044 Abort: state goes RUN->OVER during S_DRAW1 -> wr_valid=0 next cycle, no drawDoneCactus, next redraw uses full mode.
REQ-045 Back-to-back: cactusMovement stays 1 through S_DONE -> S_LATCH entered 1 cycle after return to S_IDLE.
